// File: rtl/axi_stream_input_if.sv
// AXI4-Stream character channel between the frame source and the inference front end.
`default_nettype none

interface axi_stream_input_if #(
  parameter int CHAR_LEN = 8
);
  logic [CHAR_LEN-1:0] tdata;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

`default_nettype wire

// File: rtl/axi_stream_input.sv
// AXI4-Stream slave that packs one frame of N characters into a parallel word,
// flagging short and over-long frames. Rev 1.0
`default_nettype none

module axi_stream_input #(
  parameter int N        = 4,
  parameter int CHAR_LEN = 8
) (
  input  wire logic                  ACLK,
  input  wire logic                  ARESET,
  axi_stream_input_if.slave          s_axis,
  input  wire logic                  run,
  output logic [N*CHAR_LEN-1:0]      q,
  output logic                       valid,
  output logic                       short_frame,
  output logic                       long_frame
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          tready;
  logic          accept;

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid & tready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      count       <= '0;
      q           <= '0;
      tready      <= 1'b0;
      valid       <= 1'b0;
      short_frame <= 1'b0;
      long_frame  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state       <= RECV;
            q           <= '0;
            count       <= '0;
            short_frame <= 1'b0;
            long_frame  <= 1'b0;
            tready      <= 1'b1;
          end
        end

        RECV: begin
          if (accept) begin
            for (int i = 0; i < N; i++) begin
              if (count == CW'(i)) begin
                q[i*CHAR_LEN +: CHAR_LEN] <= s_axis.tdata;
              end
            end
            // The last slot never increments count, so it cannot wrap past N-1.
            if (count == LAST_IDX) begin
              if (s_axis.tlast) begin
                state  <= DONE;
                tready <= 1'b0;
                valid  <= 1'b1;
              end else begin
                state      <= DRAIN;
                long_frame <= 1'b1;
              end
            end else if (s_axis.tlast) begin
              state       <= DONE;
              tready      <= 1'b0;
              valid       <= 1'b1;
              short_frame <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (accept && s_axis.tlast) begin
            state  <= DONE;
            tready <= 1'b0;
            valid  <= 1'b1;
          end
        end

        DONE: begin
          if (!run) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          tready <= 1'b0;
          valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_input.sv
// Self-checking bench for axi_stream_input: directed frame table, hand-written
// reset/rearm sequences and random frames against a frame-level reference model.
`default_nettype none

module tb_axi_stream_input;

  localparam int N  = 4;
  localparam int CL = 8;

  logic            clk;
  logic            rst;
  logic            run;
  logic [N*CL-1:0] q;
  logic            valid;
  logic            short_frame;
  logic            long_frame;

  axi_stream_input_if #(.CHAR_LEN(CL)) bus ();

  axi_stream_input #(.N(N), .CHAR_LEN(CL)) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .s_axis      (bus.slave),
    .run         (run),
    .q           (q),
    .valid       (valid),
    .short_frame (short_frame),
    .long_frame  (long_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    int          len;
    int          gap;
    logic [31:0] exp_q;
    logic        exp_short;
    logic        exp_long;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete frame: arm, stream len beats (last with TLAST), check result, release.
  task automatic run_frame(input logic [63:0] d, input int len, input int gap,
                           input logic [31:0] eq, input logic es, input logic el,
                           input bit drop_run, input int hold);
    int idx;
    int cyc;
    int phase;
    bit early;
    bit v;
    bit acc;
    @(negedge clk);
    run = 1'b1;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    @(negedge clk);
    chk("tready_after_arm", bus.tready, 1);
    idx = 0; cyc = 0; phase = 0; early = 0;
    while (idx < len && cyc < 100) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (phase % 3 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      phase++;
      bus.tvalid = v;
      bus.tdata  = d[idx*8 +: 8];
      bus.tlast  = (idx == len - 1);
      if (valid) early = 1;
      acc = v && bus.tready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (drop_run) run = 1'b0;
      end
      cyc++;
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    chk("beats_accepted", idx, len);
    chk("valid_early", early, 0);
    chk("valid_latency", valid, 1);
    chk("q_frame", q, eq);
    chk("short_flag", short_frame, es);
    chk("long_flag", long_frame, el);
    chk("tready_done", bus.tready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("valid_hold", valid, 1);
      chk("tready_hold", bus.tready, 0);
    end
    run = 1'b0;
    @(negedge clk);
    chk("valid_release", valid, 0);
    chk("tready_release", bus.tready, 0);
    chk("q_retained", q, eq);
  endtask

  initial begin
    logic [63:0] rd;
    logic [31:0] req;
    int          rlen;
    bit          rdrop;

    vecs[0] = '{64'h00000000_ff030201, 4, 0, 32'hff030201, 1'b0, 1'b0};
    vecs[1] = '{64'h00000000_ff030201, 4, 1, 32'hff030201, 1'b0, 1'b0};
    vecs[2] = '{64'h00000000_0000bbaa, 2, 0, 32'h0000bbaa, 1'b1, 1'b0};
    vecs[3] = '{64'h00006655_44332211, 6, 0, 32'h44332211, 1'b0, 1'b1};
    vecs[4] = '{64'h00000000_0000005a, 1, 1, 32'h0000005a, 1'b1, 1'b0};
    vecs[5] = '{64'h00000055_44332211, 5, 1, 32'h44332211, 1'b0, 1'b1};

    // Reset with traffic present.
    rst = 1'b1; run = 1'b1;
    bus.tvalid = 1'b1; bus.tdata = 8'h5c; bus.tlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", bus.tready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", q, 0);
    chk("rst_flags", {short_frame, long_frame}, 0);
    rst = 1'b0; run = 1'b0; bus.tvalid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d, vecs[i].len, vecs[i].gap, vecs[i].exp_q,
                vecs[i].exp_short, vecs[i].exp_long, 1'b0, 1);
    end

    // run held high in DONE must not rearm; run dropped mid-frame must be ignored.
    run_frame(64'h00000000_04030201, 4, 0, 32'h04030201, 1'b0, 1'b0, 1'b0, 4);
    run_frame(64'h00000000_0d0c0b0a, 4, 1, 32'h0d0c0b0a, 1'b0, 1'b0, 1'b1, 0);

    // Reset after two accepted beats, then a fresh frame.
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    bus.tvalid = 1'b1; bus.tdata = 8'h77; bus.tlast = 1'b0;
    @(negedge clk);
    bus.tdata = 8'h88;
    @(negedge clk);
    rst = 1'b1; bus.tvalid = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("midrst_q", q, 0);
    chk("midrst_tready", bus.tready, 0);
    chk("midrst_valid", valid, 0);
    rst = 1'b0;
    run_frame(64'h00000000_40302010, 4, 0, 32'h40302010, 1'b0, 1'b0, 1'b0, 0);

    // Random frames against a frame-level model: first min(len,N) chars kept, rest zero.
    for (int r = 0; r < 20; r++) begin
      rlen  = $urandom_range(1, 7);
      rd    = {$urandom(), $urandom()};
      rdrop = ($urandom_range(0, 3) == 0);
      req   = '0;
      for (int k = 0; k < N; k++) begin
        if (k < rlen) req[k*8 +: 8] = rd[k*8 +: 8];
      end
      run_frame(rd, rlen, 2, req, rlen < N, rlen > N, rdrop,
                rdrop ? 0 : $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
